pipe_ctrl_unit: RTL and testbench
=================================

PIPE_CTRL_UNIT -- requirements
Module: pipe_ctrl_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_WIDTH  32  jump address width
  REG_ADDR_WIDTH  5  register index width
  NUM_STAGES  5  pipeline stage count (min 4); stage 0 = PC, 1 = IF/ID, 2 = ID/EX, 3 = EX/MEM ...
  MC_TIMEOUT  64  max multicycle wait cycles before error
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  single clock
  rst_n  in  1  asynchronous active-low reset
  jump_en_i  in  1  EX requests redirect
  jump_addr_i  in  ADDR_WIDTH  redirect target
  ex_is_load_i  in  1  EX holds load
  ex_rd_addr_i  in  REG_ADDR_WIDTH  EX destination
  id_rs1_addr_i / id_rs2_addr_i  in  REG_ADDR_WIDTH  ID sources
  id_rs1_used_i / id_rs2_used_i  in  1  source valid
  mc_start_i  in  1  multicycle op issued in EX (pulse)
  mc_done_i  in  1  multicycle result ready (pulse)
  ext_stall_i  in  1  memory wait, freeze all
  jump_en_o  out  1  registered PC redirect
  jump_addr_o  out  ADDR_WIDTH  registered target
  stall_o  out  NUM_STAGES  per-stage hold
  flush_o  out  NUM_STAGES  per-stage bubble insert
  mc_err_o  out  1  sticky timeout flag
  stall_cnt_o  out  32  saturating stall-cycle counter
REQ-003 Clock is clk; reset is rst_n, asynchronous, active-low; everything is in one clock domain.

Function
REQ-004 States SHALL be RUN, MC_WAIT, FLUSH; FLUSH lasts exactly one cycle, then RUN.
REQ-005 Priority, high to low: ext_stall_i, pending jump, MC_WAIT, load-use.
REQ-006 ext_stall_i=1 -> stall_o all ones, flush_o all zeros, state/timeout counter frozen, same cycle (combinational).
REQ-007 Jump: jump_en_i=1 at unstalled cycle N -> cycle N+1: jump_en_o=1, jump_addr_o=captured addr, flush_o[1]=flush_o[2]=1, state FLUSH; jump_en_o pulses exactly one cycle.
REQ-008 jump_en_i while ext_stall_i=1 SHALL latch addr as pending; issue per REQ-007 on the first cycle after ext_stall_i drops; newer jump_en_i overwrites the pending address.
REQ-009 Jump in MC_WAIT is ignored (EX is occupied by the multicycle op).
REQ-010 Load-use (combinational, RUN only): ex_is_load_i & ex_rd_addr_i!=0 & ((rs1_used & rs1==rd) | (rs2_used & rs2==rd)) -> stall_o[1:0]=1, flush_o[2]=1 for that cycle.
REQ-011 mc_start_i in RUN -> MC_WAIT next cycle; in MC_WAIT: stall_o[2:0]=1, flush_o[3]=1 each cycle.
REQ-012 mc_done_i in MC_WAIT -> RUN next cycle, no stall in that next cycle; mc_done_i and mc_start_i in the same cycle -> done wins, remain RUN.
REQ-013 Timeout counter resets on MC_WAIT entry; reaching MC_TIMEOUT -> mc_err_o=1 (sticky until reset), state RUN.
REQ-014 stall_cnt_o increments on every cycle with any stall_o bit set; saturates at 32'hFFFF_FFFF.
REQ-015 Outside the above conditions stall_o and flush_o SHALL be 0.

Reset
REQ-016 rst_n=0 -> immediately: state RUN, jump_en_o=0, jump_addr_o=0, pending cleared, mc_err_o=0, stall_cnt_o=0, timeout counter=0; stall_o/flush_o=0 while rst_n=0.
REQ-017 Reset mid-MC_WAIT or mid-pending-jump SHALL discard the operation; the first cycle after release is RUN.

Verification
REQ-018 jump_en_i=1, jump_addr_i=32'h0000_0100 at cycle 10 -> cycle 11 jump_en_o=1, jump_addr_o=32'h100, flush_o=5'b00110; cycle 12 all 0.
REQ-019 ex_is_load_i=1, ex_rd=5, id_rs2=5 used -> stall_o=5'b00011, flush_o=5'b00100 same cycle; ex_rd=0 -> no stall.
REQ-020 mc_start_i at cycle 3, mc_done_i at cycle 8 -> stall_o=5'b00111, flush_o=5'b01000 in cycles 4-8, RUN at cycle 9, stall_cnt_o=5.
REQ-021 mc_start_i with no done for 64 cycles -> mc_err_o=1, state RUN, mc_err_o stays 1.
REQ-022 jump_en_i (addr 32'h200) during ext_stall_i high for cycles 5-7 -> stall_o=5'b11111 during 5-7, jump_en_o=1 with 32'h200 at cycle 9 (pending issued cycle 8).
REQ-023 rst_n low during MC_WAIT -> all outputs 0 asynchronously; state RUN after release.

Source files
------------

// File: rtl/pipe_ctrl_unit.sv
// Pipeline hazard/control unit: jump redirect, load-use interlock, multicycle
// wait with timeout, external freeze and a saturating stall-cycle counter.
module pipe_ctrl_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int NUM_STAGES     = 5,
  parameter int MC_TIMEOUT     = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      jump_en_i,
  input  logic [ADDR_WIDTH-1:0]     jump_addr_i,
  input  logic                      ex_is_load_i,
  input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr_i,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr_i,
  input  logic                      id_rs1_used_i,
  input  logic                      id_rs2_used_i,
  input  logic                      mc_start_i,
  input  logic                      mc_done_i,
  input  logic                      ext_stall_i,
  output logic                      jump_en_o,
  output logic [ADDR_WIDTH-1:0]     jump_addr_o,
  output logic [NUM_STAGES-1:0]     stall_o,
  output logic [NUM_STAGES-1:0]     flush_o,
  output logic                      mc_err_o,
  output logic [31:0]               stall_cnt_o
);

  localparam int TO_W = $clog2(MC_TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;

  state_t                state_q, state_d;
  logic [TO_W-1:0]       to_cnt_q, to_cnt_d;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_addr_q;
  logic                  take_jump;
  logic [ADDR_WIDTH-1:0] take_addr;
  logic                  load_use;
  logic                  timeout_hit;

  // EX is busy with the multicycle op in MC_WAIT, so redirects are dropped there.
  assign take_jump = !ext_stall_i && (state_q != MC_WAIT) && (jump_en_i || pend_q);
  assign take_addr = jump_en_i ? jump_addr_i : pend_addr_q;

  assign load_use = ex_is_load_i && (ex_rd_addr_i != '0) &&
                    ((id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i)) ||
                     (id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i)));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      to_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block ordering.
      state_q  <= state_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  // Next-state logic; everything holds while the external stall is active.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_d     = state_q;
    to_cnt_d    = to_cnt_q;
    timeout_hit = 1'b0;
    if (!ext_stall_i) begin
      unique case (state_q)
        RUN: begin
          if (take_jump) begin
            state_d = FLUSH;
          end else if (mc_start_i && !mc_done_i) begin
            state_d  = MC_WAIT;
            to_cnt_d = '0;
          end
        end
        MC_WAIT: begin
          if (mc_done_i) begin
            state_d = RUN;
          end else if (to_cnt_q == TO_W'(MC_TIMEOUT - 1)) begin
            state_d     = RUN;
            timeout_hit = 1'b1;
          end else begin
            to_cnt_d = to_cnt_q + TO_W'(1);
          end
        end
        FLUSH:   state_d = take_jump ? FLUSH : RUN;
        default: state_d = RUN;
      endcase
    end
  end

  // Output logic; masked while reset is asserted.
  always_comb begin
    stall_o = '0;
    flush_o = '0;
    if (rst_n) begin
      if (ext_stall_i) begin
        stall_o = '1;
      end else begin
        unique case (state_q)
          FLUSH: flush_o[2:1] = 2'b11;
          MC_WAIT: begin
            stall_o[2:0] = 3'b111;
            flush_o[3]   = 1'b1;
          end
          RUN: begin
            if (load_use && !take_jump) begin
              stall_o[1:0] = 2'b11;
              flush_o[2]   = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Jump issue, pending capture, sticky error and stall statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      jump_en_o   <= 1'b0;
      jump_addr_o <= '0;
      mc_err_o    <= 1'b0;
      stall_cnt_o <= '0;
    end else begin
      jump_en_o <= take_jump;
      if (take_jump) begin
        jump_addr_o <= take_addr;
      end
      if (ext_stall_i && jump_en_i && (state_q != MC_WAIT)) begin
        pend_q      <= 1'b1;
        pend_addr_q <= jump_addr_i;
      end else if (take_jump) begin
        pend_q <= 1'b0;
      end
      if (timeout_hit) begin
        mc_err_o <= 1'b1;
      end
      if ((|stall_o) && (stall_cnt_o != 32'hFFFF_FFFF)) begin
        stall_cnt_o <= stall_cnt_o + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench for pipe_ctrl_unit: reset, jump, load-use, multicycle wait,
// timeout, external stall with pending jump, and reset mid-operation.
module tb_pipe_ctrl_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        ex_is_load_i;
  logic [4:0]  ex_rd_addr_i, id_rs1_addr_i, id_rs2_addr_i;
  logic        id_rs1_used_i, id_rs2_used_i;
  logic        mc_start_i, mc_done_i, ext_stall_i;
  logic        jump_en_o;
  logic [31:0] jump_addr_o;
  logic [4:0]  stall_o, flush_o;
  logic        mc_err_o;
  logic [31:0] stall_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  pipe_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .ex_is_load_i(ex_is_load_i), .ex_rd_addr_i(ex_rd_addr_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .mc_start_i(mc_start_i), .mc_done_i(mc_done_i), .ext_stall_i(ext_stall_i),
    .jump_en_o(jump_en_o), .jump_addr_o(jump_addr_o),
    .stall_o(stall_o), .flush_o(flush_o),
    .mc_err_o(mc_err_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the caller states whether the cycle just ending stalled.
  task automatic tick(input bit stalled);
    if (stalled) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; jump_en_i = 1'b1; jump_addr_i = 32'h55;
    ex_is_load_i = 1'b0; ex_rd_addr_i = '0; id_rs1_addr_i = '0; id_rs2_addr_i = '0;
    id_rs1_used_i = 1'b0; id_rs2_used_i = 1'b0;
    mc_start_i = 1'b0; mc_done_i = 1'b0; ext_stall_i = 1'b1;
    #4;
    check("rst_stall", stall_o, 5'b00000);
    check("rst_flush", flush_o, 5'b00000);
    check("rst_jump_en", jump_en_o, 1'b0);
    check("rst_jump_addr", jump_addr_o, 32'h0);
    check("rst_err", mc_err_o, 1'b0);
    check("rst_cnt", stall_cnt_o, 32'd0);
    @(posedge clk); #1;
    check("rst_hold_jump_en", jump_en_o, 1'b0);
    jump_en_i = 1'b0; ext_stall_i = 1'b0; rst_n = 1'b1;
    tick(0);

    // Jump redirect
    jump_en_i = 1'b1; jump_addr_i = 32'h0000_0100; #1;
    check("jump_req_flush", flush_o, 5'b00000);
    tick(0); jump_en_i = 1'b0; #1;
    check("jump_en_pulse", jump_en_o, 1'b1);
    check("jump_addr", jump_addr_o, 32'h100);
    check("jump_flush", flush_o, 5'b00110);
    check("jump_stall", stall_o, 5'b00000);
    tick(0);
    check("jump_en_end", jump_en_o, 1'b0);
    check("jump_flush_end", flush_o, 5'b00000);

    // Load-use interlock
    ex_is_load_i = 1'b1; ex_rd_addr_i = 5'd5; id_rs2_addr_i = 5'd5; id_rs2_used_i = 1'b1;
    id_rs1_addr_i = 5'd3; id_rs1_used_i = 1'b1; #1;
    check("lu_rs2_stall", stall_o, 5'b00011);
    check("lu_rs2_flush", flush_o, 5'b00100);
    tick(1);
    ex_rd_addr_i = 5'd0; id_rs2_addr_i = 5'd0; #1;
    check("lu_rd_zero", stall_o, 5'b00000);
    ex_rd_addr_i = 5'd7; id_rs1_addr_i = 5'd7; id_rs1_used_i = 1'b0;
    id_rs2_addr_i = 5'd7; id_rs2_used_i = 1'b0; #1;
    check("lu_unused", stall_o, 5'b00000);
    id_rs1_used_i = 1'b1; #1;
    check("lu_rs1_stall", stall_o, 5'b00011);
    tick(1);
    ex_is_load_i = 1'b0; #1;
    check("lu_not_load", stall_o, 5'b00000);
    id_rs1_used_i = 1'b0;
    check("lu_cnt", stall_cnt_o, 32'(exp_cnt));

    // Multicycle op, jump ignored while waiting
    mc_start_i = 1'b1; #1;
    check("mc_start_stall", stall_o, 5'b00000);
    tick(0); mc_start_i = 1'b0; #1;
    check("mc_wait_stall", stall_o, 5'b00111);
    check("mc_wait_flush", flush_o, 5'b01000);
    jump_en_i = 1'b1; jump_addr_i = 32'h300;
    tick(1); jump_en_i = 1'b0; #1;
    check("mc_jump_ignored", jump_en_o, 1'b0);
    check("mc_wait_stall2", stall_o, 5'b00111);
    tick(1); tick(1); tick(1);
    mc_done_i = 1'b1; #1;
    check("mc_done_stall", stall_o, 5'b00111);
    tick(1); mc_done_i = 1'b0; #1;
    check("mc_run_stall", stall_o, 5'b00000);
    check("mc_run_flush", flush_o, 5'b00000);
    check("mc_jump_never", jump_en_o, 1'b0);
    check("mc_cnt", stall_cnt_o, 32'(exp_cnt));

    // Start and done together: remain RUN
    mc_start_i = 1'b1; mc_done_i = 1'b1; #1;
    tick(0); mc_start_i = 1'b0; mc_done_i = 1'b0; #1;
    check("start_done_run", stall_o, 5'b00000);

    // External stall with pending jump overwritten by a newer one
    ext_stall_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h180; #1;
    check("ext_stall", stall_o, 5'b11111);
    check("ext_flush", flush_o, 5'b00000);
    tick(1); jump_addr_i = 32'h200; #1;
    check("ext_no_jump", jump_en_o, 1'b0);
    tick(1); jump_en_i = 1'b0; #1;
    check("ext_stall3", stall_o, 5'b11111);
    tick(1); ext_stall_i = 1'b0; #1;
    check("pend_issue_stall", stall_o, 5'b00000);
    check("pend_issue_flush", flush_o, 5'b00000);
    tick(0);
    check("pend_jump_en", jump_en_o, 1'b1);
    check("pend_jump_addr", jump_addr_o, 32'h200);
    check("pend_flush", flush_o, 5'b00110);
    tick(0);
    check("pend_jump_end", jump_en_o, 1'b0);
    check("ext_cnt", stall_cnt_o, 32'(exp_cnt));

    // Multicycle timeout
    mc_start_i = 1'b1; tick(0); mc_start_i = 1'b0; #1;
    check("to_wait1", stall_o, 5'b00111);
    repeat (63) tick(1);
    check("to_wait64", stall_o, 5'b00111);
    check("to_err_before", mc_err_o, 1'b0);
    tick(1);
    check("to_run", stall_o, 5'b00000);
    check("to_err", mc_err_o, 1'b1);
    repeat (3) tick(0);
    check("to_err_sticky", mc_err_o, 1'b1);
    check("to_cnt", stall_cnt_o, 32'(exp_cnt));

    // Reset in the middle of MC_WAIT
    mc_start_i = 1'b1; tick(0); mc_start_i = 1'b0; #1;
    check("rmc_wait", stall_o, 5'b00111);
    rst_n = 1'b0; #1;
    check("rmc_stall", stall_o, 5'b00000);
    check("rmc_flush", flush_o, 5'b00000);
    check("rmc_err", mc_err_o, 1'b0);
    check("rmc_cnt", stall_cnt_o, 32'd0);
    check("rmc_addr", jump_addr_o, 32'h0);
    exp_cnt = 0;
    @(posedge clk); #1; rst_n = 1'b1; #1;
    check("rmc_run", stall_o, 5'b00000);
    tick(0);
    check("rmc_run2", stall_o, 5'b00000);

    // Reset discards a pending jump
    ext_stall_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h400;
    tick(1); jump_en_i = 1'b0; rst_n = 1'b0; #1;
    ext_stall_i = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    tick(0);
    check("rpend_no_jump", jump_en_o, 1'b0);
    tick(0);
    check("rpend_no_jump2", jump_en_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
